mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the P5 MIPS core.
- Sequences the IFU (PC write, IR write, next-PC select), register file, ALU and data memory through the FETCH/DECODE/EXE/MEM/WB states.
- Decodes the IR output, stalls on data-memory wait, and keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
instr  in  32  IR output (instruction under execution)
zero  in  1  ALU equality flag for beq
mem_ready  in  1  data memory completes access this cycle
pc_wr  out  1  PC write enable
ir_wr  out  1  IR write enable
npc_op  out  2  00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr)
reg_wr  out  1  GRF write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  00 ALU result, 01 memory data, 10 PC+4
alu_src  out  1  0 rt data, 1 extended imm
alu_op  out  2  00 add, 01 sub, 10 or, 11 lui (imm<<16)
ext_op  out  1  1 sign-extend, 0 zero-extend
mem_req  out  1  data memory access request
mem_wr  out  1  data memory write (valid with mem_req)
state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXE, 3 MEM, 4 WB
illegal  out  1  sticky: unsupported instruction decoded
instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- Decode fields: op=instr[31:26], funct=instr[5:0].
- Supported instructions:
  - addu (op 0, funct 21h), subu (0/23h), jr (0/08h), nop (instr==0)
  - ori (0Dh), lui (0Fh), lw (23h), sw (2Bh), beq (04h), j (02h), jal (03h)
- All strobes (pc_wr, ir_wr, reg_wr, mem_req, mem_wr) are Moore outputs of state plus decoded instr. They are forced 0 while reset=0. Unlisted outputs are 0 in a given state.
- Reset (async, reset=0): state=FETCH, instr_cnt=0, illegal=0, all strobes 0. Takes effect mid-instruction with no partial writes; first FETCH strobes appear in the cycle after release.
- FETCH: pc_wr=1, ir_wr=1, npc_op=00 -> DECODE.
- DECODE:
  - j: pc_wr=1, npc_op=10 -> FETCH
  - jr: pc_wr=1, npc_op=11 -> FETCH
  - nop -> FETCH
  - jal -> WB
  - illegal: no strobes, illegal<=1 -> FETCH, not counted
  - others -> EXE
- EXE: alu_src/alu_op/ext_op set per instruction.
  - addu (00), subu (01): alu_src=0
  - ori: alu_src=1, op 10, ext_op=0
  - lui: alu_src=1, op 11
  - lw/sw: alu_src=1, op 00, ext_op=1
  - beq: alu_src=0, op 01, npc_op=01, pc_wr=zero -> FETCH
  - lw/sw -> MEM; R-type/ori/lui -> WB
  - EXE holds alu_* values into MEM/WB.
- MEM: mem_req=1, mem_wr=(sw). Stay in MEM while mem_ready=0. On mem_ready=1: sw -> FETCH, lw -> WB.
- WB: reg_wr=1.
  - R-type: reg_dst=01, wd_sel=00
  - ori/lui: reg_dst=00, wd_sel=00
  - lw: reg_dst=00, wd_sel=01
  - jal: reg_dst=10, wd_sel=10, plus pc_wr=1, npc_op=10
  - -> FETCH
- Latencies (cycles per instruction):
  - j/jr/nop: 2
  - jal/beq: 3
  - R/ori/lui: 4
  - sw: 4+waits
  - lw: 5+waits
- instr_cnt increments by 1 on every transition into FETCH from DECODE/EXE/MEM/WB, except the illegal path. Wraps modulo 2^CNT_W.
- beq not-taken still retires (count+1).
- illegal stays 1 until reset.
- state value 5-7 unreachable; if entered -> FETCH, no strobes.

Test Plan:
- Reset low for 3 cycles mid-WB of addu, then release -> reg_wr never 1 during reset; state=0, instr_cnt=0; next cycle pc_wr=ir_wr=1.
- addu 0x00221821 with mem_ready=1 -> states 0,1,2,4,0; reg_wr=1 in WB with reg_dst=01; instr_cnt=1 after 4 cycles.
- lw 0x8C220004, mem_ready low 3 cycles -> MEM held 4 cycles with mem_req=1, mem_wr=0; WB wd_sel=01; total 8 cycles.
- beq 0x10220003 with zero=1, then again with zero=0 -> pc_wr=1 with npc_op=01 in EXE only when zero=1; both retire (cnt+2).
- jal 0x0C000C00 -> DECODE no strobes; WB reg_wr=1, reg_dst=10, wd_sel=10, pc_wr=1, npc_op=10; j 0x08000C00 -> pc_wr in DECODE, 2 cycles.
- Instruction 0xFC000000 -> illegal=1 after DECODE, no writes, instr_cnt unchanged; following nop 0x00000000 retires in 2 cycles with illegal still 1.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXE/MEM/WB sequencing,
// instruction decode, retired count and sticky illegal flag.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_op,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_rtype;
  logic       w_nop;
  logic       w_addu;
  logic       w_subu;
  logic       w_jr;
  logic       w_ori;
  logic       w_lui;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_j;
  logic       w_jal;
  logic       w_legal;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rtype = (w_op == 6'h00);
  assign w_nop   = (instr == 32'h0);
  assign w_addu  = w_rtype && (w_funct == 6'h21);
  assign w_subu  = w_rtype && (w_funct == 6'h23);
  assign w_jr    = w_rtype && (w_funct == 6'h08);
  assign w_ori   = (w_op == 6'h0D);
  assign w_lui   = (w_op == 6'h0F);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2B);
  assign w_beq   = (w_op == 6'h04);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);

  assign w_legal = w_nop | w_addu | w_subu | w_jr | w_ori | w_lui
                 | w_lw | w_sw | w_beq | w_j | w_jal;

  // State sequencing, retire counter and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_state   <= S_FETCH;
          end else if (w_j || w_jr || w_nop) begin
            r_state <= S_FETCH;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_jal) begin
            r_state <= S_WB;
          end else begin
            r_state <= S_EXE;
          end
        end
        S_EXE: begin
          if (w_beq) begin
            r_state <= S_FETCH;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_lw || w_sw) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_sw) begin
              r_state <= S_FETCH;
              r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Moore control outputs from state and decoded IR; silenced in reset
  always_comb begin
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    npc_op  = 2'b00;
    reg_wr  = 1'b0;
    reg_dst = 2'b00;
    wd_sel  = 2'b00;
    alu_src = 1'b0;
    alu_op  = 2'b00;
    ext_op  = 1'b0;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    if (reset) begin
      if (r_state == S_EXE || r_state == S_MEM ||
          r_state == S_WB) begin
        if (w_ori) begin
          alu_src = 1'b1;
          alu_op  = 2'b10;
        end else if (w_lui) begin
          alu_src = 1'b1;
          alu_op  = 2'b11;
        end else if (w_lw || w_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end else if (w_subu || w_beq) begin
          alu_op  = 2'b01;
        end
      end
      case (r_state)
        S_FETCH: begin
          pc_wr = 1'b1;
          ir_wr = 1'b1;
        end
        S_DECODE: begin
          if (w_j) begin
            pc_wr  = 1'b1;
            npc_op = 2'b10;
          end else if (w_jr) begin
            pc_wr  = 1'b1;
            npc_op = 2'b11;
          end
        end
        S_EXE: begin
          if (w_beq) begin
            pc_wr  = zero;
            npc_op = 2'b01;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_wr  = w_sw;
        end
        S_WB: begin
          reg_wr = 1'b1;
          if (w_addu || w_subu) begin
            reg_dst = 2'b01;
          end else if (w_lw) begin
            wd_sel = 2'b01;
          end else if (w_jal) begin
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
            pc_wr   = 1'b1;
            npc_op  = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign state     = r_state;
  assign illegal   = r_illegal;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected output vectors queued
// by each scenario and compared by a scoreboard monitor.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_wr, ir_wr, reg_wr, alu_src, ext_op;
  logic        mem_req, mem_wr, illegal;
  logic [1:0]  npc_op, reg_dst, wd_sel, alu_op;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_cyc = 0;
  logic [31:0] exp_cnt = 0;
  logic [17:0] sb[$];

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] SUBU = 32'h00221823;
  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] SW   = 32'hAC220004;
  localparam logic [31:0] BEQ  = 32'h10220003;
  localparam logic [31:0] JAL  = 32'h0C000C00;
  localparam logic [31:0] JMP  = 32'h08000C00;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] ORI  = 32'h342200FF;
  localparam logic [31:0] LUI  = 32'h3C021234;
  localparam logic [31:0] BAD  = 32'hFC000000;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr),
    .npc_op(npc_op), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_src(alu_src), .alu_op(alu_op),
    .ext_op(ext_op), .mem_req(mem_req), .mem_wr(mem_wr),
    .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ev(
    input logic [2:0] st, input logic pc, input logic ir,
    input logic [1:0] npc, input logic rw, input logic [1:0] rd,
    input logic [1:0] wd, input logic as, input logic [1:0] ao,
    input logic eo, input logic mr, input logic mw);
    return {st, pc, ir, npc, rw, rd, wd, as, ao, eo, mr, mw};
  endfunction

  wire [17:0] obs = {state, pc_wr, ir_wr, npc_op, reg_wr,
                     reg_dst, wd_sel, alu_src, alu_op, ext_op,
                     mem_req, mem_wr};

  // Scoreboard: compare each queued expectation mid-cycle
  always @(negedge clk) begin
    logic [17:0] e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cyc++;
      n_chk++;
      if (obs !== e)
        $display("FAIL outputs cycle %0d: got %b want %b",
                 n_cyc, obs, e);
      else
        n_pass++;
    end
  end

  task automatic cyc(input logic r, input logic [31:0] iv,
                     input logic z, input logic rdy,
                     input logic [17:0] e);
    @(negedge clk);
    reset = r;
    instr = iv;
    zero = z;
    mem_ready = rdy;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] iv);
    cyc(1, iv, 0, 1, ev(0,1,1,0,0,0,0,0,0,0,0,0));
    #1;
    n_chk++;
    if (instr_cnt !== exp_cnt)
      $display("FAIL instr_cnt: got %0d want %0d", instr_cnt, exp_cnt);
    else
      n_pass++;
  endtask

  task automatic test_reset;
    logic [17:0] z0;
    z0 = '0;
    cyc(0, 0, 0, 1, z0);
    cyc(0, 0, 0, 1, z0);
    #1;
    n_chk++;
    if (illegal !== 1'b0 || instr_cnt !== 32'd0)
      $display("FAIL reset_regs: got ill=%b cnt=%0d want 0/0",
               illegal, instr_cnt);
    else
      n_pass++;
    fetch(ADDU);
    cyc(1, ADDU, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, ADDU, 0, 1, ev(2,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) cyc(0, ADDU, 0, 1, z0);
    #1;
    n_chk++;
    if (instr_cnt !== 32'd0)
      $display("FAIL mid_wb_reset_cnt: got %0d want 0", instr_cnt);
    else
      n_pass++;
    fetch(32'h0);
    cyc(1, 32'h0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    exp_cnt++;
  endtask

  task automatic test_rtype(input logic [31:0] iv, input logic [1:0] ao);
    fetch(iv);
    cyc(1, iv, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, iv, 0, 1, ev(2,0,0,0,0,0,0,0,ao,0,0,0));
    cyc(1, iv, 0, 1, ev(4,0,0,0,1,1,0,0,ao,0,0,0));
    exp_cnt++;
  endtask

  task automatic test_imm(input logic [31:0] iv, input logic [1:0] ao);
    fetch(iv);
    cyc(1, iv, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, iv, 0, 1, ev(2,0,0,0,0,0,0,1,ao,0,0,0));
    cyc(1, iv, 0, 1, ev(4,0,0,0,1,0,0,1,ao,0,0,0));
    exp_cnt++;
  endtask

  task automatic test_lw;
    fetch(LW);
    cyc(1, LW, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, LW, 0, 0, ev(2,0,0,0,0,0,0,1,0,1,0,0));
    for (int i = 0; i < 3; i++)
      cyc(1, LW, 0, 0, ev(3,0,0,0,0,0,0,1,0,1,1,0));
    cyc(1, LW, 0, 1, ev(3,0,0,0,0,0,0,1,0,1,1,0));
    cyc(1, LW, 0, 1, ev(4,0,0,0,1,0,1,1,0,1,0,0));
    exp_cnt++;
  endtask

  task automatic test_sw;
    fetch(SW);
    cyc(1, SW, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, SW, 0, 0, ev(2,0,0,0,0,0,0,1,0,1,0,0));
    cyc(1, SW, 0, 0, ev(3,0,0,0,0,0,0,1,0,1,1,1));
    cyc(1, SW, 0, 1, ev(3,0,0,0,0,0,0,1,0,1,1,1));
    exp_cnt++;
  endtask

  task automatic test_beq;
    fetch(BEQ);
    cyc(1, BEQ, 1, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, BEQ, 1, 1, ev(2,1,0,1,0,0,0,0,1,0,0,0));
    exp_cnt++;
    fetch(BEQ);
    cyc(1, BEQ, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, BEQ, 0, 1, ev(2,0,0,1,0,0,0,0,1,0,0,0));
    exp_cnt++;
  endtask

  task automatic test_jumps;
    fetch(JAL);
    cyc(1, JAL, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc(1, JAL, 0, 1, ev(4,1,0,2,1,2,2,0,0,0,0,0));
    exp_cnt++;
    fetch(JMP);
    cyc(1, JMP, 0, 1, ev(1,1,0,2,0,0,0,0,0,0,0,0));
    exp_cnt++;
    fetch(JR);
    cyc(1, JR, 0, 1, ev(1,1,0,3,0,0,0,0,0,0,0,0));
    exp_cnt++;
  endtask

  task automatic test_illegal;
    fetch(BAD);
    cyc(1, BAD, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    fetch(32'h0);
    n_chk++;
    if (illegal !== 1'b1)
      $display("FAIL illegal_set: got %b want 1", illegal);
    else
      n_pass++;
    cyc(1, 32'h0, 0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    exp_cnt++;
    fetch(ADDU);
    n_chk++;
    if (illegal !== 1'b1)
      $display("FAIL illegal_sticky: got %b want 1", illegal);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_rtype(ADDU, 2'b00);
    test_rtype(SUBU, 2'b01);
    test_imm(ORI, 2'b10);
    test_imm(LUI, 2'b11);
    test_lw();
    test_sw();
    test_beq();
    test_jumps();
    test_illegal();
    #10;
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
